// File: rtl/perf_counter_ctrl.sv
// Performance counter window controller: routes pipeline data requests to the
// d-cache or counter bank, and runs a round-robin-arbitrated counter dump engine.
module perf_counter_ctrl #(
    parameter int          NUM_SLOTS = 10,
    parameter logic [31:0] BASE_ADDR = 32'hFFFFFFD8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byte_enable,
    output logic        mem_resp,
    output logic [31:0] mem_rdata,
    output logic        dcache_read,
    output logic        dcache_write,
    output logic [31:0] dcache_address,
    output logic [31:0] dcache_wdata,
    output logic [3:0]  dcache_byte_enable,
    input  logic [31:0] dcache_rdata,
    input  logic        dcache_resp,
    output logic        counter_read,
    output logic        counter_write,
    output logic [31:0] counter_address,
    input  logic [31:0] counter_data,
    input  logic        dbg_dump_req,
    input  logic        dbg_clear,
    output logic        dbg_busy,
    output logic        dbg_valid,
    output logic [3:0]  dbg_index,
    output logic [31:0] dbg_data,
    output logic        dbg_done
);

    typedef enum logic [2:0] {IDLE, CACHE, CTR, RESP, DUMP} state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_SLOTS - 1);

    state_t      state_q, state_d;
    logic        pending_q, pending_d;
    logic        clear_q, clear_d;
    logic        rr_q, rr_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] rdata_q, rdata_d;
    logic        dbg_valid_q, dbg_valid_d;
    logic [3:0]  dbg_index_q, dbg_index_d;
    logic [31:0] dbg_data_q, dbg_data_d;
    logic        dbg_done_q, dbg_done_d;

    logic cpu_req;
    logic win_hit;
    logic go_dump;

    assign cpu_req = mem_read | mem_write;
    assign win_hit = mem_address[31:2] >= BASE_ADDR[31:2];

    always_comb begin
        state_d            = state_q;
        pending_d          = pending_q;
        clear_d            = clear_q;
        rr_d               = rr_q;
        idx_d              = idx_q;
        rdata_d            = rdata_q;
        dbg_valid_d        = 1'b0;
        dbg_index_d        = 4'd0;
        dbg_data_d         = 32'd0;
        go_dump            = 1'b0;
        mem_resp           = 1'b0;
        mem_rdata          = 32'd0;
        dcache_read        = 1'b0;
        dcache_write       = 1'b0;
        dcache_address     = 32'd0;
        dcache_wdata       = 32'd0;
        dcache_byte_enable = 4'd0;
        counter_read       = 1'b0;
        counter_write      = 1'b0;
        counter_address    = 32'd0;

        unique case (state_q)
            IDLE: begin
                // rr_q set means the dump engine lost the last contest
                if (cpu_req && (!pending_q || !rr_q)) begin
                    state_d = win_hit ? CTR : CACHE;
                    if (pending_q) rr_d = 1'b1;
                end else if (pending_q) begin
                    go_dump = 1'b1;
                    state_d = DUMP;
                    idx_d   = 4'd0;
                    if (cpu_req) rr_d = 1'b0;
                end
            end
            CACHE: begin
                dcache_read        = mem_read & ~mem_write;
                dcache_write       = mem_write;
                dcache_address     = mem_address;
                dcache_wdata       = mem_wdata;
                dcache_byte_enable = mem_byte_enable;
                mem_resp           = dcache_resp;
                mem_rdata          = dcache_rdata;
                if (dcache_resp) state_d = IDLE;
            end
            CTR: begin
                counter_address = {mem_address[31:2], 2'b00};
                counter_read    = ~mem_write;
                counter_write   = mem_write;
                rdata_d         = mem_write ? 32'd0 : counter_data;
                state_d         = RESP;
            end
            RESP: begin
                mem_resp  = 1'b1;
                mem_rdata = rdata_q;
                state_d   = IDLE;
            end
            DUMP: begin
                counter_address = BASE_ADDR + {26'd0, idx_q, 2'b00};
                counter_read    = 1'b1;
                counter_write   = clear_q;
                dbg_valid_d     = 1'b1;
                dbg_index_d     = idx_q;
                dbg_data_d      = counter_data;
                if (idx_q == LAST_IDX) begin
                    idx_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (go_dump) begin
            pending_d = 1'b0;
        end else if (dbg_dump_req && !pending_q && state_q != DUMP) begin
            pending_d = 1'b1;
            clear_d   = dbg_clear;
        end

        dbg_done_d = dbg_valid_q && (dbg_index_q == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            clear_q     <= 1'b0;
            rr_q        <= 1'b0;
            idx_q       <= 4'd0;
            rdata_q     <= 32'd0;
            dbg_valid_q <= 1'b0;
            dbg_index_q <= 4'd0;
            dbg_data_q  <= 32'd0;
            dbg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            clear_q     <= clear_d;
            rr_q        <= rr_d;
            idx_q       <= idx_d;
            rdata_q     <= rdata_d;
            dbg_valid_q <= dbg_valid_d;
            dbg_index_q <= dbg_index_d;
            dbg_data_q  <= dbg_data_d;
            dbg_done_q  <= dbg_done_d;
        end
    end

    assign dbg_busy  = pending_q | (state_q == DUMP);
    assign dbg_valid = dbg_valid_q;
    assign dbg_index = dbg_index_q;
    assign dbg_data  = dbg_data_q;
    assign dbg_done  = dbg_done_q;

endmodule

// File: doc/perf_counter_ctrl.md
# perf_counter_ctrl

Sits between the pipeline's data-memory port, the data cache and the performance counter bank, and sequences every access to the counter window 0xFFFFFFD8–0xFFFFFFFC. It decodes each data request and routes it either to the d-cache or to a counter read/clear cycle. It also runs a debug dump engine that sweeps all ten counter slots out on a streaming port, optionally clearing each slot as it is read. The engine and the pipeline share the counter bank under round-robin arbitration.

## Interface
Parameters:
- NUM_SLOTS, 10: counter slots swept by a dump, one per word from 0xFFFFFFD8.
- BASE_ADDR, 32'hFFFFFFD8: first counter slot address.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_read / mem_write  in  1  pipeline data request, held stable until mem_resp
- mem_address  in  32  request address
- mem_wdata  in  32  store data
- mem_byte_enable  in  4  store byte mask
- mem_resp  out  1  one-cycle completion pulse to pipeline
- mem_rdata  out  32  load data, valid with mem_resp
- dcache_read / dcache_write  out  1  d-cache request
- dcache_address  out  32; dcache_wdata  out  32; dcache_byte_enable  out  4
- dcache_rdata  in  32; dcache_resp  in  1
- counter_read / counter_write  out  1  counter bank strobes; counter_write clears the addressed slot
- counter_address  out  32  word-aligned slot address
- counter_data  in  32  combinational read data from bank
- dbg_dump_req  in  1  request a dump (level or pulse)
- dbg_clear  in  1  sampled with dbg_dump_req; clear slots as dumped
- dbg_busy  out  1  dump pending or in progress
- dbg_valid  out  1; dbg_index  out  4; dbg_data  out  32  registered dump stream
- dbg_done  out  1  one-cycle pulse after last slot

## Operation
- Window hit: mem_address[31:2] >= BASE_ADDR[31:2]. Slot address = {mem_address[31:2],2'b00}. The low address bits are ignored.
- Request with both read and write set is treated as a write.
- FSM states: IDLE, CACHE, CTR, RESP, DUMP.
- IDLE:
  - A cache request (non-window) goes to CACHE.
  - A window request goes to CTR.
  - A pending dump goes to DUMP.
  - If a CPU request and a pending dump coincide, grant goes to the requester that lost the previous contested arbitration. After reset, the CPU wins the first contest.
- CACHE:
  - dcache_* are driven from mem_* (zero in all other states).
  - mem_resp = dcache_resp and mem_rdata = dcache_rdata, combinationally.
  - On dcache_resp, go to IDLE.
- CTR: one cycle. Drive counter_address and assert counter_read (load) or counter_write (store).
  - For a load, latch counter_data.
  - For a store, latch zero.
  - Store data is discarded; any store clears the slot.
  - Go to RESP.
- RESP: one cycle. mem_resp=1 and mem_rdata=latched value. Go to IDLE.
- dbg_dump_req sets a pending flag and latches dbg_clear. The flag is cleared on entry to DUMP. A request arriving while pending or in DUMP is ignored.
- DUMP: index i runs 0..NUM_SLOTS-1, one slot per cycle.
  - counter_address = BASE_ADDR + 4·i.
  - counter_read=1, and counter_write = latched clear. The pre-clear value is captured.
  - dbg_valid/dbg_index/dbg_data are registered from that cycle.
  - After slot NUM_SLOTS-1, go to IDLE, and dbg_done pulses on the cycle after the last dbg_valid.
- Slots 0xFFFFFFE8/0xFFFFFFEC are dumped normally (the bank returns 0).
- DUMP is never preempted. A CPU request waits, held stable by the pipeline.
- dbg_busy = pending | (state==DUMP).

## Timing
- Reset (async, any state): state IDLE, pending=0, arbitration pointer=CPU, dump index 0.
- All outputs are 0 during reset, including mem_rdata, dbg_data, dbg_index and dbg_done. An interrupted dump produces no dbg_done.
- Counter load/store: request seen in IDLE at cycle 0; CTR at cycle 1; mem_resp at cycle 2. Next request is accepted at cycle 3.
- Cache access: 1 cycle of arbitration overhead, then d-cache latency. mem_resp is coincident with dcache_resp.
- Dump: DUMP occupies NUM_SLOTS cycles. dbg_valid is high for NUM_SLOTS consecutive cycles starting 1 cycle after DUMP entry, and dbg_done follows immediately.
- counter_read/counter_write are never asserted outside CTR/DUMP, and never for more than one cycle per slot access.

## Test plan
- Load from 0xFFFFFFE4 with counter_data=0x1234 -> counter_read high exactly at cycle 1; mem_resp and mem_rdata=0x1234 at cycle 2 only; no dcache_read.
- Store to 0xFFFFFFF6 (misaligned) -> counter_write one cycle with counter_address=0xFFFFFFF4; mem_resp one cycle later, mem_rdata=0.
- Load from 0x00000100 with dcache_resp 3 cycles after dcache_read -> mem_resp coincident with dcache_resp, mem_rdata=dcache_rdata; counter strobes stay 0.
- dbg_dump_req with dbg_clear=1 -> 10 cycles of dbg_valid with dbg_index 0..9 and addresses 0xFFFFFFD8..0xFFFFFFFC, counter_write high on each, dbg_done one cycle after index 9.
- Dump request and window load in the same IDLE cycle, twice -> first contest: CPU served first, then dump. Second contest: dump served first; the CPU load completes 2 cycles after dbg_done's DUMP exit.
- rst_n low during DUMP at index 4 -> all outputs 0 immediately, dbg_busy=0, no dbg_done. After release, an idle bank sees no strobes.
